// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter driving a shared 32-bit barrel shifter into a one-entry response buffer.
// Latency: a request accepted at a clock edge is presented on resp_* in the following cycle.
// Backpressure: a full buffer with resp_ready low holds both ready lines low; draining and a new grant may share a cycle.
module shift_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_b,
  input  logic [1:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        can_accept;
  logic        grant0, grant1, grant_any;
  logic [31:0] sel_a;
  logic [4:0]  sel_b;
  logic [1:0]  sel_op;
  logic        is_shl, fill;
  logic [31:0] s0, s1, s2, s3, s4, s5;
  logic [31:0] shift_res;

  function automatic logic [31:0] bit_rev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Round-robin grant; ready lines are held low while in reset.
  always_comb begin
    can_accept = (state_q == EMPTY) || resp_ready;
    grant0     = reset_n && can_accept && req0_valid && (!req1_valid || last_grant_q);
    grant1     = reset_n && can_accept && req1_valid && (!req0_valid || !last_grant_q);
    grant_any  = grant0 || grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux feeding the shared shifter.
  always_comb begin
    sel_a  = grant1 ? req1_a  : req0_a;
    sel_b  = grant1 ? req1_b  : req0_b;
    sel_op = grant1 ? req1_op : req0_op;
  end

  // Logarithmic right shifter; left shifts reuse it by reversing operand and result.
  always_comb begin
    is_shl    = (sel_op == 2'b00);
    fill      = (sel_op == 2'b11) && sel_a[31];
    s0        = is_shl ? bit_rev(sel_a) : sel_a;
    s1        = sel_b[0] ? {fill, s0[31:1]}          : s0;
    s2        = sel_b[1] ? {{2{fill}}, s1[31:2]}     : s1;
    s3        = sel_b[2] ? {{4{fill}}, s2[31:4]}     : s2;
    s4        = sel_b[3] ? {{8{fill}}, s3[31:8]}     : s3;
    s5        = sel_b[4] ? {{16{fill}}, s4[31:16]}   : s4;
    shift_res = is_shl ? bit_rev(s5) : s5;
  end

  // Buffer occupancy: a grant always fills it, a drain without grant empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant_any) state_d = FULL;
      FULL:    if (grant_any) state_d = FULL;
               else if (resp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign resp_valid = (state_q == FULL);

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Response payload and round-robin pointer update on every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_data    <= 32'd0;
      resp_id      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (grant_any) begin
      resp_data    <= shift_res;
      resp_id      <= grant1;
      last_grant_q <= grant1;
    end
  end

endmodule
